// File: rtl/adc_frame_aligner.sv
// Frame alignment and sample assembly for two-lane-per-channel serial ADC links.
// Optional per-channel ramp-error counters are enabled with ADC_RAMP_CHECK_EN.
module adc_frame_aligner #(
  parameter int         NCH           = 4,
  parameter int         RES           = 14,
  parameter logic [7:0] FRAME_PATTERN = 8'hF0,
  parameter int         LOCK_CNT      = 16,
  parameter int         LOSS_CNT      = 4,
  parameter int         SETTLE        = 3
) (
  input  logic                  CLKDIV,
  input  logic                  cpu_resetn,
  input  logic                  CE,
  input  logic [7:0]            frame_i,
  input  logic [8*NCH-1:0]      lane_d0_i,
  input  logic [8*NCH-1:0]      lane_d1_i,
  output logic                  bitslip_o,
  output logic                  aligned_o,
  output logic                  lost_o,
  output logic                  align_err_o,
  output logic [2:0]            slip_cnt_o,
  output logic [RES*NCH-1:0]    samples_o,
  output logic                  sample_valid_o,
  output logic [16*NCH-1:0]     ramp_err_o
);

  // state  | meaning
  // IDLE   | disabled, counters and align_err cleared
  // CHECK  | counting consecutive frame matches
  // SLIP   | one-cycle bitslip strobe
  // WAIT   | settle timer after a slip
  // LOCKED | aligned, counting consecutive misses
  typedef enum logic [2:0] {ST_IDLE, ST_CHECK, ST_SLIP, ST_WAIT, ST_LOCKED} state_t;

  localparam logic [7:0] LOCK_LAST   = 8'(LOCK_CNT - 1);
  localparam logic [7:0] LOSS_LAST   = 8'(LOSS_CNT - 1);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [7:0]  match_cnt_q, match_cnt_d;
  logic [7:0]  miss_cnt_q, miss_cnt_d;
  logic [3:0]  settle_q, settle_d;
  logic [2:0]  slip_cnt_q, slip_cnt_d;
  logic        align_err_q, align_err_d;
  logic        lost_q, lost_d;
  logic        frame_match;

  assign frame_match = (frame_i == FRAME_PATTERN);

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    settle_d    = settle_q;
    slip_cnt_d  = slip_cnt_q;
    align_err_d = align_err_q;
    lost_d      = 1'b0;
    if (!CE) begin
      state_d     = ST_IDLE;
      match_cnt_d = '0;
      miss_cnt_d  = '0;
      settle_d    = '0;
      slip_cnt_d  = '0;
      align_err_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_CHECK;
          match_cnt_d = '0;
          miss_cnt_d  = '0;
          slip_cnt_d  = '0;
          align_err_d = 1'b0;
        end
        ST_CHECK: begin
          if (frame_match) begin
            if (match_cnt_q == LOCK_LAST) begin
              state_d     = ST_LOCKED;
              match_cnt_d = '0;
              miss_cnt_d  = '0;
            end else begin
              match_cnt_d = match_cnt_q + 8'd1;
            end
          end else begin
            match_cnt_d = '0;
            state_d     = ST_SLIP;
          end
        end
        ST_SLIP: begin
          slip_cnt_d = slip_cnt_q + 3'd1;
          settle_d   = SETTLE_LOAD;
          state_d    = ST_WAIT;
        end
        ST_WAIT: begin
          // WAIT always follows a slip, so a zero count here means it just wrapped
          if (slip_cnt_q == 3'd0) begin
            align_err_d = 1'b1;
            state_d     = ST_CHECK;
          end else if (settle_q == 4'd0) begin
            state_d = ST_CHECK;
          end else begin
            settle_d = settle_q - 4'd1;
          end
        end
        ST_LOCKED: begin
          if (frame_match) begin
            miss_cnt_d = '0;
          end else if (miss_cnt_q == LOSS_LAST) begin
            lost_d      = 1'b1;
            miss_cnt_d  = '0;
            match_cnt_d = '0;
            state_d     = ST_CHECK;
          end else begin
            miss_cnt_d = miss_cnt_q + 8'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  logic [8*NCH-1:0]   d0_q, d1_q;
  logic [16*NCH-1:0]  word;
  logic [RES*NCH-1:0] samples_d, samples_q;
  logic               vld1_q, vld_q;
  logic               unused_word;

  always_comb begin
    word      = '0;
    samples_d = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int i = 0; i < 8; i++) begin
        word[16*c + 15 - 2*i] = d1_q[8*c + i];
        word[16*c + 14 - 2*i] = d0_q[8*c + i];
      end
      samples_d[RES*c +: RES] = word[16*c + 16 - RES +: RES];
    end
  end

  assign unused_word = ^word;

  always_ff @(posedge CLKDIV or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state_q     <= ST_IDLE;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      settle_q    <= '0;
      slip_cnt_q  <= '0;
      align_err_q <= 1'b0;
      lost_q      <= 1'b0;
      d0_q        <= '0;
      d1_q        <= '0;
      samples_q   <= '0;
      vld1_q      <= 1'b0;
      vld_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      settle_q    <= settle_d;
      slip_cnt_q  <= slip_cnt_d;
      align_err_q <= align_err_d;
      lost_q      <= lost_d;
      d0_q        <= lane_d0_i;
      d1_q        <= lane_d1_i;
      samples_q   <= samples_d;
      vld1_q      <= (state_q == ST_LOCKED);
      vld_q       <= vld1_q;
    end
  end

  assign bitslip_o      = (state_q == ST_SLIP);
  assign aligned_o      = (state_q == ST_LOCKED);
  assign lost_o         = lost_q;
  assign align_err_o    = align_err_q;
  assign slip_cnt_o     = slip_cnt_q;
  assign samples_o      = samples_q;
  assign sample_valid_o = vld_q;

`ifdef ADC_RAMP_CHECK_EN
  logic [RES*NCH-1:0] prev_q;
  logic               prev_vld_q;
  logic [16*NCH-1:0]  rerr_q, rerr_d;

  always_comb begin
    logic [RES-1:0] nxt;
    rerr_d = rerr_q;
    nxt    = '0;
    if (!CE) begin
      rerr_d = '0;
    end else if (vld_q && prev_vld_q) begin
      for (int c = 0; c < NCH; c++) begin
        nxt = prev_q[RES*c +: RES] + 1'b1;
        if ((samples_q[RES*c +: RES] != nxt) && (rerr_q[16*c +: 16] != 16'hFFFF))
          rerr_d[16*c +: 16] = rerr_q[16*c +: 16] + 16'd1;
      end
    end
  end

  always_ff @(posedge CLKDIV or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      rerr_q     <= '0;
    end else begin
      prev_q     <= samples_q;
      prev_vld_q <= vld_q;
      rerr_q     <= rerr_d;
    end
  end

  assign ramp_err_o = rerr_q;
`else
  assign ramp_err_o = '0;
`endif

endmodule
